// File: rtl/sha3_input_padder.sv
// sha3_input_padder
//   Turns a stream of message chunks into rate-sized Keccak input blocks with
//   SHA3 / SHAKE domain-separation padding (pad10*1) applied to the last
//   chunk. There is one held output block. A new chunk is accepted in the
//   same cycle that the held block is consumed, so the module can deliver one
//   block per cycle.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   mode_in       : 00 SHAKE128, 01 SHAKE256, 10 SHA3-256, 11 SHA3-512.
//                   Sampled only on the first chunk of a message.
//   data_in       : chunk data; byte i is at [8i+7:8i]
//   data_len      : chunk length in bits (must be whole bytes)
//   in_finish     : the chunk is the last one of its message
//   in_valid/in_ready : chunk handshake
//   block_out     : padded rate block; bytes at and above the rate are zero
//   block_mode    : mode of the message that owns the block
//   block_first   : first block of a message (core clears its state)
//   block_last    : final block of a message (core starts squeezing)
//   block_valid/block_ready : block handshake
//   err           : sticky protocol error; the offending chunk is dropped

module sha3_pad_lane #(
    parameter int IDX = 0
) (
    input  logic [7:0] din,
    input  logic [7:0] rate,
    input  logic [7:0] len_b,
    input  logic [7:0] ds,
    input  logic       pad_en,
    output logic [7:0] dout
);
    localparam logic [7:0] IDX_B = IDX[7:0];

    // Data is kept below len_b. The DS byte lands at len_b and 0x80 lands at
    // rate-1. When len_b == rate-1 the two XORs merge into DS|0x80.
    always_comb begin
        dout = 8'h00;
        if (IDX_B < rate) begin
            if (IDX_B < len_b)                 dout = din;
            if (pad_en && IDX_B == len_b)      dout = dout ^ ds;
            if (pad_en && IDX_B == rate - 8'd1) dout = dout ^ 8'h80;
        end
    end
endmodule

module sha3_input_padder #(
    parameter int NUM_LANES = 168
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode_in,
    input  logic [NUM_LANES*8-1:0]   data_in,
    input  logic [10:0]              data_len,
    input  logic                     in_finish,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_LANES*8-1:0]   block_out,
    output logic [1:0]               block_mode,
    output logic                     block_first,
    output logic                     block_last,
    output logic                     block_valid,
    input  logic                     block_ready,
    output logic                     err
);
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, EXTRA = 2'd2} state_t;

    function automatic logic [7:0] rate_of(input logic [1:0] m);
        case (m)
            2'b00:   rate_of = 8'd168;
            2'b01:   rate_of = 8'd136;
            2'b10:   rate_of = 8'd136;
            default: rate_of = 8'd72;
        endcase
    endfunction

    function automatic logic [7:0] ds_of(input logic [1:0] m);
        ds_of = m[1] ? 8'h06 : 8'h1F;
    endfunction

    state_t state_q, state_d;
    logic   msg_active;   // a message has chunks accepted but no final chunk yet

    // While a message is in progress, block_mode still holds its locked mode.
    logic [1:0]            eff_mode;
    logic [7:0]            rate_in;
    logic [10:0]           rate_bits;
    logic [7:0]            len_b;
    logic                  bad_chunk;
    logic                  accept;
    logic                  load_new;
    logic                  to_extra;
    logic [NUM_LANES*8-1:0] padded;
    logic [NUM_LANES*8-1:0] pad_blk;

    assign eff_mode  = msg_active ? block_mode : mode_in;
    assign rate_in   = rate_of(eff_mode);
    assign rate_bits = {rate_in, 3'b000};
    assign len_b     = data_len[10:3];
    assign bad_chunk = (data_len[2:0] != 3'd0)
                     || (!in_finish && data_len != rate_bits)
                     || ( in_finish && data_len >  rate_bits);
    assign accept    = in_valid && in_ready;
    assign load_new  = accept && !bad_chunk;
    // A final chunk that exactly fills the rate needs a separate pad-only block.
    assign to_extra  = in_finish && (len_b == rate_in);

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            sha3_pad_lane #(.IDX(g)) u_lane (
                .din    (data_in[8*g +: 8]),
                .rate   (rate_in),
                .len_b  (len_b),
                .ds     (ds_of(eff_mode)),
                .pad_en (in_finish && !to_extra),
                .dout   (padded[8*g +: 8])
            );
        end
    endgenerate

    // Pad-only block: DS in byte 0, 0x80 in byte rate-1. It uses the locked mode.
    always_comb begin
        logic [7:0] r;
        r       = rate_of(block_mode);
        pad_blk = (NUM_LANES*8)'(ds_of(block_mode))
                | ((NUM_LANES*8)'(8'h80) << {r - 8'd1, 3'b000});
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_new) state_d = to_extra ? EXTRA : HOLD;
            HOLD:    if (block_ready) begin
                         if (load_new) state_d = to_extra ? EXTRA : HOLD;
                         else          state_d = IDLE;
                     end
            EXTRA:   if (block_ready) state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        block_valid = (state_q != IDLE);
        in_ready    = !rst && ((state_q == IDLE) || (state_q == HOLD && block_ready));
    end

    // Held block, message tracking and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            block_out   <= '0;
            block_mode  <= 2'b00;
            block_first <= 1'b0;
            block_last  <= 1'b0;
            msg_active  <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (accept && bad_chunk) begin
                // Drop the chunk and abort the message, so the next chunk re-locks the mode.
                err        <= 1'b1;
                msg_active <= 1'b0;
            end
            if (load_new) begin
                block_out   <= padded;
                block_mode  <= eff_mode;
                block_first <= !msg_active;
                block_last  <= in_finish && !to_extra;
                msg_active  <= !in_finish;
            end else if (state_q == EXTRA && block_ready) begin
                block_out   <= pad_blk;
                block_first <= 1'b0;
                block_last  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sha3_input_padder.sv
module tb_sha3_input_padder;
    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode_in;
    logic [1343:0] data_in;
    logic [10:0]   data_len;
    logic          in_finish, in_valid, in_ready;
    logic [1343:0] block_out;
    logic [1:0]    block_mode;
    logic          block_first, block_last, block_valid, block_ready, err;

    sha3_input_padder dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .data_in(data_in),
        .data_len(data_len), .in_finish(in_finish), .in_valid(in_valid),
        .in_ready(in_ready), .block_out(block_out), .block_mode(block_mode),
        .block_first(block_first), .block_last(block_last),
        .block_valid(block_valid), .block_ready(block_ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1343:0] blk;
        logic [1:0]    mode;
        logic          first;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   nblk  = 0;

    // Message bytes: byte i = i*3+5, giving distinct non-zero values across the block.
    function automatic logic [1343:0] mk(input int n);
        logic [1343:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = 8'(i*3 + 5);
        return r;
    endfunction

    task automatic push(input logic [1343:0] b, input logic [1:0] m,
                        input logic f, input logic l);
        exp_t e;
        e.blk = b; e.mode = m; e.first = f; e.last = l;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Offer a chunk (data_in is always fully populated so that masking is exercised).
    // On return we are 1 time unit after the accepting edge.
    task automatic send(input logic [1:0] m, input logic [10:0] len, input logic fin);
        int n;
        mode_in = m; data_len = len; in_finish = fin; data_in = mk(168); in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!in_ready && n < 50);
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL accept_timeout got=in_ready0 exp=in_ready1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; mode_in = ~m; data_len = 11'h7FF; in_finish = ~fin; data_in = '1;
    endtask

    // Monitor: compares every consumed block against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && block_valid && block_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_block got=blk%0d exp=none", nblk);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (block_out !== e.blk || block_mode !== e.mode ||
                        block_first !== e.first || block_last !== e.last) begin
                        int k;
                        k = 0;
                        for (int i = 167; i >= 0; i--)
                            if (block_out[8*i +: 8] !== e.blk[8*i +: 8]) k = i;
                        bad++;
                        $display("FAIL block%0d byte%0d got=%h exp=%h mode got=%0d exp=%0d first got=%0d exp=%0d last got=%0d exp=%0d",
                                 nblk, k, block_out[8*k +: 8], e.blk[8*k +: 8],
                                 block_mode, e.mode, block_first, e.first, block_last, e.last);
                    end
                end
                nblk++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1343:0] e, ec, ed;
        rst = 1'b1; mode_in = 2'b00; data_in = '0; data_len = '0;
        in_finish = 1'b0; in_valid = 1'b0; block_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", block_valid, 0);
        chk("rst_block_zero", block_out == '0, 1);
        chk("rst_flags", {block_mode, block_first, block_last, err}, 0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        step();

        // SHA3-256, empty message
        e = '0; e[7:0] = 8'h06; e[135*8 +: 8] = 8'h80;
        push(e, 2'b10, 1, 1);
        send(2'b10, 11'd0, 1'b1);

        // SHA3-512, 71 bytes: pad bytes merge at rate-1
        e = mk(71); e[71*8 +: 8] = 8'h86;
        push(e, 2'b11, 1, 1);
        send(2'b11, 11'd568, 1'b1);

        // SHAKE128, full-rate final chunk: data block followed by pad-only block
        push(mk(168), 2'b00, 1, 0);
        e = '0; e[7:0] = 8'h1F; e[167*8 +: 8] = 8'h80;
        push(e, 2'b00, 0, 1);
        send(2'b00, 11'd1344, 1'b1);
        @(negedge clk);
        chk("extra_in_ready", in_ready, 0);
        step();

        // SHAKE256 two chunks; mode_in changes on the second chunk and must be ignored
        push(mk(136), 2'b01, 1, 0);
        e = mk(3); e[3*8 +: 8] = 8'h1F; e[135*8 +: 8] = 8'h80;
        push(e, 2'b01, 0, 1);
        send(2'b01, 11'd1088, 1'b0);
        send(2'b11, 11'd24, 1'b1);
        repeat (3) step();

        // Backpressure: the held block stays stable, then the next block follows with no gap
        block_ready = 1'b0;
        ec = mk(1); ec[15:8] = 8'h06; ec[135*8 +: 8] = 8'h80;
        push(ec, 2'b10, 1, 1);
        send(2'b10, 11'd8, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {block_valid, in_ready, block_out == ec, block_first, block_last, block_mode},
                {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10});
        end
        step();
        block_ready = 1'b1;
        ed = mk(2); ed[23:16] = 8'h06; ed[71*8 +: 8] = 8'h80;
        push(ed, 2'b11, 1, 1);
        send(2'b11, 11'd16, 1'b1);
        @(negedge clk);
        chk("no_bubble", {block_valid, block_out == ed}, 2'b11);
        repeat (2) step();

        // Errors: a bad non-final length is dropped; a non-byte final length aborts the message
        send(2'b10, 11'd800, 1'b0);
        @(negedge clk);
        chk("err_set", {err, block_valid}, 2'b10);
        step();
        push(mk(136), 2'b01, 1, 0);
        send(2'b01, 11'd1088, 1'b0);
        send(2'b01, 11'd13, 1'b1);
        e = '0; e[7:0] = 8'h06; e[71*8 +: 8] = 8'h80;
        push(e, 2'b11, 1, 1);
        send(2'b11, 11'd0, 1'b1);
        repeat (3) step();

        // Reset while the pad-only block is pending
        block_ready = 1'b0;
        send(2'b00, 11'd1344, 1'b1);
        @(negedge clk);
        chk("extra_held", {in_ready, block_valid}, 2'b01);
        step(); rst = 1'b1;
        step(); rst = 1'b0; block_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_block", {block_valid, err}, 0);
        end

        // Drain
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
